rng_word_collector: RTL and testbench

Parametrised successor to the single-bit TRNG capture register. It packs the serial bit stream from a padlock-style TRNG (rnd_bit qualified by done) into WORD_W-bit words and buffers them in a DEPTH-entry FIFO. Words are delivered over a valid/ready handshake to a downstream consumer (UART tx, host bridge). It sits between padlock_top and any word-wide consumer.

---
 rtl/rng_word_collector.sv | 198 +++++++++++++++++++
 tb/tb_rng_word_collector.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rng_word_collector.sv
// ----------------------------------------------------------------------------
// rng_word_collector
//
// Packs the serial bit stream of a padlock-style TRNG (rnd_bit qualified by
// bit_valid) into WORD_W-bit words and queues them in a DEPTH-entry FIFO that
// is drained over a valid/ready handshake.
//
// Parameters:
//   WORD_W  output word width in bits (>= 2)
//   DEPTH   FIFO depth in words (>= 2, power of two)
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   en          collection enable; 0 ignores incoming bits, partial word held
//   flush       synchronous clear of partial word, FIFO and debias state
//   rnd_bit     raw random bit from the TRNG
//   bit_valid   rnd_bit qualifier; one bit consumed per high cycle
//   word_out    FIFO head word (0 while the FIFO is empty)
//   word_valid  FIFO non-empty
//   word_ready  consumer accepts word_out this cycle
//   level       number of words currently held in the FIFO
//   overflow    sticky flag: a completed word was dropped because of a full FIFO
//   clr_ovf     synchronous clear of overflow (a same-edge drop wins)
//
// Optional feature (compile-time macro VN_DEBIAS_EN):
//   When defined, a von Neumann debiaser filters the raw stream before the
//   shift register: pairs 10/01 yield the first bit, pairs 11/00 yield nothing.
//   When undefined, every qualified raw bit goes straight to the shift register.
// ----------------------------------------------------------------------------
module rng_word_collector #(
    parameter int WORD_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         flush,
    input  logic                         rnd_bit,
    input  logic                         bit_valid,
    output logic [WORD_W-1:0]            word_out,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    input  logic                         clr_ovf
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    // Next FIFO fill level; push and pop are pre-qualified so the result
    // always stays inside 0..DEPTH.
    function automatic logic [LVL_W-1:0] level_next(
        input logic [LVL_W-1:0] cur,
        input logic             push,
        input logic             pop
    );
        logic [LVL_W-1:0] nxt;
        nxt = cur;
        if (push && !pop) begin
            nxt = cur + LVL_W'(1);
        end else if (pop && !push) begin
            nxt = cur - LVL_W'(1);
        end
        return nxt;
    endfunction

    // ------------------------------------------------------------------
    // Stage p0: accepted-bit selection (optionally von Neumann debiased)
    // ------------------------------------------------------------------
    logic acc_bit_p0;
    logic vld_p0;

`ifdef VN_DEBIAS_EN
    localparam logic [0:0] WAIT_FIRST  = 1'b0;
    localparam logic [0:0] WAIT_SECOND = 1'b1;

    logic [0:0] vn_state;
    logic       vn_b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vn_state <= WAIT_FIRST;
            vn_b0    <= 1'b0;
        end else if (flush) begin
            vn_state <= WAIT_FIRST;
            vn_b0    <= 1'b0;
        end else if (en && bit_valid) begin
            if (vn_state == WAIT_FIRST) begin
                vn_b0    <= rnd_bit;
                vn_state <= WAIT_SECOND;
            end else begin
                vn_state <= WAIT_FIRST;
            end
        end
    end

    // Only an unequal pair produces a bit, and that bit is the first of the pair.
    always_comb begin
        acc_bit_p0 = vn_b0;
        vld_p0     = en && bit_valid && (vn_state == WAIT_SECOND) && (rnd_bit != vn_b0);
    end
`else
    always_comb begin
        acc_bit_p0 = rnd_bit;
        vld_p0     = en && bit_valid;
    end
`endif

    // ------------------------------------------------------------------
    // Stage p1: shift register and word completion
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] sreg_p1;
    logic [CNT_W-1:0]  bit_cnt_p1;
    logic [WORD_W-1:0] word_p1;
    logic              vld_p1;

    // New bits enter at the top, so the first bit of a word ends in bit 0.
    always_comb begin
        word_p1 = {acc_bit_p0, sreg_p1[WORD_W-1:1]};
        vld_p1  = vld_p0 && (bit_cnt_p1 == CNT_LAST);
    end

    // ------------------------------------------------------------------
    // Stage p2: word FIFO
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] mem_p2 [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;

    always_comb begin
        full = (level == LVL_FULL);
        pop  = word_valid && word_ready && !flush;
        // A pop on the same edge frees the slot the completing word needs.
        push = vld_p1 && (!full || pop) && !flush;
        drop = vld_p1 && full && !pop && !flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_p1    <= '0;
            bit_cnt_p1 <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
        end else begin
            if (flush) begin
                sreg_p1    <= '0;
                bit_cnt_p1 <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                level      <= '0;
            end else begin
                if (vld_p0) begin
                    sreg_p1    <= word_p1;
                    // Wraps to 0 even when the completed word is dropped.
                    bit_cnt_p1 <= (bit_cnt_p1 == CNT_LAST) ? '0 : bit_cnt_p1 + CNT_W'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                level <= level_next(level, push, pop);
            end

            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage is not reset; word_out is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_p2[wr_ptr] <= word_p1;
        end
    end

    always_comb begin
        word_valid = (level != '0);
        word_out   = word_valid ? mem_p2[rd_ptr] : '0;
    end

endmodule

// File: tb/tb_rng_word_collector.sv
module tb_rng_word_collector;

    logic       clk;
    logic       rst;
    logic       en;
    logic       flush;
    logic       rnd_bit;
    logic       bit_valid;
    logic [7:0] word_out;
    logic       word_valid;
    logic       word_ready;
    logic [2:0] level;
    logic       overflow;
    logic       clr_ovf;

    int n_vec = 0;
    int n_err = 0;

    rng_word_collector #(.WORD_W(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .flush      (flush),
        .rnd_bit    (rnd_bit),
        .bit_valid  (bit_valid),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .level      (level),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One raw qualified input for one cycle; word_ready held as given.
    task automatic raw_bit(input logic b, input logic rdy);
        rnd_bit    = b;
        bit_valid  = 1'b1;
        word_ready = rdy;
        step();
        bit_valid  = 1'b0;
        word_ready = 1'b0;
    endtask

    // Delivers one accepted bit; rdy is asserted only on the edge that
    // accepts it (in debias mode the bit is encoded as the pair b,~b).
    task automatic send_bit(input logic b, input logic rdy);
`ifdef VN_DEBIAS_EN
        raw_bit(b, 1'b0);
        raw_bit(~b, rdy);
`else
        raw_bit(b, rdy);
`endif
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            send_bit(w[i], 1'b0);
        end
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check_val({tag, "_valid"}, 32'(word_valid), 32'd1);
        check_val({tag, "_word"}, 32'(word_out), 32'(exp));
        word_ready = 1'b1;
        step();
        word_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] w;
        rst        = 1'b1;
        en         = 1'b1;
        flush      = 1'b0;
        rnd_bit    = 1'b0;
        bit_valid  = 1'b0;
        word_ready = 1'b0;
        clr_ovf    = 1'b0;
        #12;
        check_val("rst_valid", 32'(word_valid), 32'd0);
        check_val("rst_word", 32'(word_out), 32'd0);
        check_val("rst_level", 32'(level), 32'd0);
        check_val("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        step();

        // Basic pack: 1,0,1,1,0,0,1,0 -> 0x4D
        w = 8'h4D;
        for (int i = 0; i < 7; i++) send_bit(w[i], 1'b0);
        check_val("pack_valid_early", 32'(word_valid), 32'd0);
        send_bit(w[7], 1'b0);
        check_val("pack_level", 32'(level), 32'd1);
        pop_check("pack", 8'h4D);
        check_val("pack_drained", 32'(level), 32'd0);

        // Pop while empty is ignored
        word_ready = 1'b1;
        step();
        word_ready = 1'b0;
        check_val("empty_pop_level", 32'(level), 32'd0);
        check_val("empty_word", 32'(word_out), 32'd0);

        // Backpressure and overflow
        for (int i = 1; i <= 4; i++) send_word(8'(i));
        check_val("bp_level4", 32'(level), 32'd4);
        check_val("bp_ovf_before", 32'(overflow), 32'd0);
        send_word(8'h05);
        check_val("bp_level_full", 32'(level), 32'd4);
        check_val("bp_ovf_set", 32'(overflow), 32'd1);
        pop_check("bp_r1", 8'h01);
        pop_check("bp_r2", 8'h02);
        pop_check("bp_r3", 8'h03);
        pop_check("bp_r4", 8'h04);
        check_val("bp_empty", 32'(word_valid), 32'd0);
        check_val("bp_ovf_sticky", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check_val("bp_ovf_clr", 32'(overflow), 32'd0);

        // Full with simultaneous push and pop
        send_word(8'h11);
        send_word(8'h12);
        send_word(8'h13);
        send_word(8'h14);
        w = 8'h06;
        for (int i = 0; i < 7; i++) send_bit(w[i], 1'b0);
        check_val("full_level_pre", 32'(level), 32'd4);
        send_bit(w[7], 1'b1);
        check_val("full_level_post", 32'(level), 32'd4);
        check_val("full_ovf", 32'(overflow), 32'd0);
        pop_check("full_r1", 8'h12);
        pop_check("full_r2", 8'h13);
        pop_check("full_r3", 8'h14);
        pop_check("full_r4", 8'h06);
        check_val("full_empty", 32'(level), 32'd0);

        // en gating: 3 bits, 10 gated cycles, 5 bits -> 0xA5
        w = 8'hA5;
        for (int i = 0; i < 3; i++) send_bit(w[i], 1'b0);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bit_valid = i[0];
            rnd_bit   = 1'($urandom);
            step();
        end
        bit_valid = 1'b0;
        en = 1'b1;
        check_val("en_level_gated", 32'(level), 32'd0);
        for (int i = 3; i < 8; i++) send_bit(w[i], 1'b0);
        check_val("en_level", 32'(level), 32'd1);
        pop_check("en", 8'hA5);

        // Flush: full FIFO with overflow, partial word, then flush
        for (int i = 0; i < 5; i++) send_word(8'h30 + 8'(i));
        check_val("fl_ovf_pre", 32'(overflow), 32'd1);
        w = 8'hFF;
        for (int i = 0; i < 5; i++) send_bit(w[i], 1'b0);
        flush      = 1'b1;
        bit_valid  = 1'b1;
        rnd_bit    = 1'b1;
        word_ready = 1'b1;
        step();
        flush      = 1'b0;
        bit_valid  = 1'b0;
        word_ready = 1'b0;
        check_val("fl_level", 32'(level), 32'd0);
        check_val("fl_valid", 32'(word_valid), 32'd0);
        check_val("fl_word", 32'(word_out), 32'd0);
        check_val("fl_ovf_kept", 32'(overflow), 32'd1);
        send_word(8'hC3);
        check_val("fl_fresh_level", 32'(level), 32'd1);
        check_val("fl_fresh_word", 32'(word_out), 32'hC3);

        // Async reset mid-word with a word queued
        w = 8'hFF;
        for (int i = 0; i < 3; i++) send_bit(w[i], 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_val("ar_valid", 32'(word_valid), 32'd0);
        check_val("ar_word", 32'(word_out), 32'd0);
        check_val("ar_level", 32'(level), 32'd0);
        check_val("ar_ovf", 32'(overflow), 32'd0);
        #3;
        rst = 1'b0;
        step();
        send_word(8'h96);
        check_val("ar_fresh_level", 32'(level), 32'd1);
        pop_check("ar_fresh", 8'h96);

`ifdef VN_DEBIAS_EN
        // Debias: useful pairs interleaved with 11 and 00 junk pairs
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? 8'hB4 : 8'h2E;
            for (int i = 0; i < 8; i++) begin
                raw_bit(w[i], 1'b0);
                raw_bit(~w[i], 1'b0);
                raw_bit(i[0], 1'b0);
                raw_bit(i[0], 1'b0);
            end
        end
        check_val("vn_level", 32'(level), 32'd2);
        pop_check("vn_w1", 8'hB4);
        pop_check("vn_w2", 8'h2E);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
